// File: rtl/mod_shift_pkg.sv
// Shared definitions for the word-serial shift register.
//   state_e  : session state (IDLE, BUSY, DONE)
//   calc_cw  : width of a counter able to hold the values 0..n
package mod_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mod_shift_reg_words.sv
// Word-serial shift register: an N x W parallel buffer loaded in one cycle and
// serialised one word per accepted shift, while new words enter at the far end.
//
// Ports:
//   iClk, iRst_n   clock (rising edge) and asynchronous active-low reset
//   iLoad          load iData into the buffer and start a session
//   iStart         start a receive-only session, buffer left as is
//   iData          parallel load data (W*N bits)
//   iShiftEn       shift one word this cycle (only acted on while busy)
//   iWord          word entering the buffer on a shift
//   oWord          word at the output end of the buffer
//   iOutputLoad    gate for oData
//   oData          buffer contents when iOutputLoad=1, else zero
//   oCount         words remaining in the current session
//   oBusy          session in progress
//   oDone          one-cycle pulse after the last shift of a session
//
// Handshake: there is no back-pressure. A word is transferred on every rising
// edge where iShiftEn=1 while oBusy=1 and neither iLoad nor iStart is high;
// iShiftEn outside a session is dropped.
module mod_shift_reg_words
    import mod_shift_pkg::*;
#(
    parameter int W         = 32,
    parameter int N         = 64,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CW        = calc_cw(N)
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iLoad,
    input  logic            iStart,
    input  logic [W*N-1:0]  iData,
    input  logic            iShiftEn,
    input  logic [W-1:0]    iWord,
    output logic [W-1:0]    oWord,
    input  logic            iOutputLoad,
    output logic [W*N-1:0]  oData,
    output logic [CW-1:0]   oCount,
    output logic            oBusy,
    output logic            oDone
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(N);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    logic [W*N-1:0] buffer_q, buffer_d;
    logic [W*N-1:0] shifted;
    logic [CW-1:0]  count_q, count_d;
    state_e         state_q, state_d;
    logic           done_q, done_d;

    // Direction is fixed at elaboration: the output end and the entry end of
    // the buffer swap with LSB_FIRST.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted = {iWord, buffer_q[W*N-1:W]};
            assign oWord   = buffer_q[W-1:0];
        end else begin : g_msb_first
            assign shifted = {buffer_q[W*(N-1)-1:0], iWord};
            assign oWord   = buffer_q[W*N-1 -: W];
        end
    endgenerate

    always_comb begin
        buffer_d = buffer_q;
        count_d  = count_q;
        state_d  = state_q;
        done_d   = 1'b0;
        // Load beats start, and either beats a coincident shift; a load in
        // BUSY restarts the session without a done pulse.
        if (iLoad) begin
            buffer_d = iData;
            count_d  = COUNT_FULL;
            state_d  = ST_BUSY;
        end else if (iStart) begin
            count_d  = COUNT_FULL;
            state_d  = ST_BUSY;
        end else if ((state_q == ST_BUSY) && iShiftEn) begin
            buffer_d = shifted;
            count_d  = count_q - COUNT_LAST;
            if (count_q == COUNT_LAST) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            buffer_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
        end else begin
            buffer_q <= buffer_d;
            count_q  <= count_d;
            state_q  <= state_d;
            done_q   <= done_d;
        end
    end

    assign oData  = iOutputLoad ? buffer_q : '0;
    assign oCount = count_q;
    assign oBusy  = (state_q == ST_BUSY);
    assign oDone  = done_q;

endmodule

// File: tb/tb_mod_shift_reg_words.sv
// Self-checking bench: two instances (LSB-first and MSB-first, W=8, N=4) driven
// with identical stimulus and compared against a queue-based word model.
module tb_mod_shift_reg_words;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);
    localparam int SW = 2 * W + 2 * CW + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           load, start, shift_en, out_load;
    logic [W*N-1:0] data;
    logic [W-1:0]   word;

    logic [W-1:0]   word_l, word_m;
    logic [W*N-1:0] data_l, data_m;
    logic [CW-1:0]  count_l, count_m;
    logic           busy_l, busy_m, done_l, done_m;

    int n_checks = 0;
    int n_fails  = 0;

    mod_shift_reg_words #(.W(W), .N(N), .LSB_FIRST(1'b1)) u_lsb (
        .iClk(clk), .iRst_n(rst_n), .iLoad(load), .iStart(start), .iData(data),
        .iShiftEn(shift_en), .iWord(word), .oWord(word_l), .iOutputLoad(out_load),
        .oData(data_l), .oCount(count_l), .oBusy(busy_l), .oDone(done_l)
    );

    mod_shift_reg_words #(.W(W), .N(N), .LSB_FIRST(1'b0)) u_msb (
        .iClk(clk), .iRst_n(rst_n), .iLoad(load), .iStart(start), .iData(data),
        .iShiftEn(shift_en), .iWord(word), .oWord(word_m), .iOutputLoad(out_load),
        .oData(data_m), .oCount(count_m), .oBusy(busy_m), .oDone(done_m)
    );

    // ---------------- reference model ----------------
    // ml/mm hold the buffer as words indexed 0..N-1 (index 0 = bits W-1:0).
    logic [W-1:0] ml[$];
    logic [W-1:0] mm[$];
    int           m_count;
    bit           m_busy;
    bit           m_done;

    function automatic void model_reset();
        ml = {};
        mm = {};
        for (int i = 0; i < N; i++) begin
            ml.push_back('0);
            mm.push_back('0);
        end
        m_count = 0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic void model_step(input bit ld, input bit st,
                                       input logic [W*N-1:0] d, input bit sh,
                                       input logic [W-1:0] w);
        logic [W-1:0] tmp;
        m_done = 1'b0;
        if (ld) begin
            ml = {};
            mm = {};
            for (int i = 0; i < N; i++) begin
                ml.push_back(d[i*W +: W]);
                mm.push_back(d[i*W +: W]);
            end
            m_count = N;
            m_busy  = 1'b1;
        end else if (st) begin
            m_count = N;
            m_busy  = 1'b1;
        end else if (m_busy && sh) begin
            tmp = ml.pop_front();   // word 0 leaves, newcomer becomes word N-1
            ml.push_back(w);
            tmp = mm.pop_back();    // word N-1 leaves, newcomer becomes word 0
            mm.push_front(w);
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endfunction

    function automatic logic [W*N-1:0] pack_l();
        logic [W*N-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = ml[i];
        return r;
    endfunction

    function automatic logic [W*N-1:0] pack_m();
        logic [W*N-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = mm[i];
        return r;
    endfunction

    function automatic logic [SW-1:0] exp_status();
        return {ml[0], mm[N-1], CW'(m_count), CW'(m_count),
                m_busy, m_busy, m_done, m_done};
    endfunction

    function automatic logic [SW-1:0] act_status();
        return {word_l, word_m, count_l, count_m, busy_l, busy_m, done_l, done_m};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; shift_en = 1'b0; out_load = 1'b0;
        data = '0; word = '0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        model_step(load, start, data, shift_en, word);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        out_load = 1'b1;
        #1;
        n_checks++;
        if (act_status() !== exp_status()) begin
            n_fails++;
            $display("FAIL reset_status act=%h exp=%h", act_status(), exp_status());
        end
        n_checks++;
        if ({data_l, data_m} !== '0) begin
            n_fails++;
            $display("FAIL reset_odata act=%h/%h exp=0", data_l, data_m);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Reset in the middle of a session, between clock edges.
        load = 1'b1; data = 32'h44332211; tick();
        load = 1'b0; shift_en = 1'b1; word = 8'hA0; tick();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({word_l, word_m, count_l, count_m, busy_l, busy_m} !== '0) begin
            n_fails++;
            $display("FAIL async_reset act=%h exp=0",
                     {word_l, word_m, count_l, count_m, busy_l, busy_m});
        end
        n_checks++;
        if ({data_l, data_m} !== '0) begin
            n_fails++;
            $display("FAIL async_reset_odata act=%h/%h exp=0", data_l, data_m);
        end
        rst_n = 1'b1;
        word = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (act_status() !== exp_status()) begin
                n_fails++;
                $display("FAIL post_reset_shift act=%h exp=%h", act_status(), exp_status());
            end
        end
        idle_inputs();
    endtask

    task automatic test_full_session();
        idle_inputs();
        load = 1'b1; data = 32'h44332211; tick();
        load = 1'b0; shift_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (word_l !== 8'(8'h11 * (i + 1)) || word_m !== 8'(8'h44 - 8'h11 * i)) begin
                n_fails++;
                $display("FAIL session_oword[%0d] act=%h/%h exp=%h/%h", i, word_l, word_m,
                         8'(8'h11 * (i + 1)), 8'(8'h44 - 8'h11 * i));
            end
            n_checks++;
            if (act_status() !== exp_status()) begin
                n_fails++;
                $display("FAIL session_status[%0d] act=%h exp=%h", i, act_status(), exp_status());
            end
            word = 8'(8'hA0 + i);
            tick();
        end
        shift_en = 1'b0;
        n_checks++;
        if ({busy_l, busy_m, done_l, done_m} !== 4'b0011 || act_status() !== exp_status()) begin
            n_fails++;
            $display("FAIL session_done act=%h exp=%h", act_status(), exp_status());
        end
        out_load = 1'b1;
        #1;
        n_checks++;
        if (data_l !== 32'hA3A2A1A0 || data_m !== 32'hA0A1A2A3 ||
            data_l !== pack_l() || data_m !== pack_m()) begin
            n_fails++;
            $display("FAIL session_odata act=%h/%h exp=a3a2a1a0/a0a1a2a3", data_l, data_m);
        end
        out_load = 1'b0;
        #1;
        n_checks++;
        if ({data_l, data_m} !== '0) begin
            n_fails++;
            $display("FAIL session_odata_gated act=%h/%h exp=0", data_l, data_m);
        end
        tick();
        n_checks++;
        if (done_l !== 1'b0 || act_status() !== exp_status()) begin
            n_fails++;
            $display("FAIL session_done_pulse act=%h exp=%h", act_status(), exp_status());
        end
    endtask

    task automatic test_receive_only();
        int pulses;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        start = 1'b1; tick();
        start = 1'b0; shift_en = 1'b1;
        pulses = 0;
        for (int i = 0; i <= N; i++) begin
            n_checks++;
            if (count_l !== CW'(N - i) || act_status() !== exp_status()) begin
                n_fails++;
                $display("FAIL rx_count[%0d] act=%h exp=%h", i, act_status(), exp_status());
            end
            if (done_l) pulses++;
            word = 8'(i + 1);
            tick();
        end
        // The last tick above was a fifth shift request issued in DONE.
        if (done_l) pulses++;
        n_checks++;
        if (pulses !== 1) begin
            n_fails++;
            $display("FAIL rx_done_pulses act=%0d exp=1", pulses);
        end
        out_load = 1'b1;
        #1;
        n_checks++;
        if (count_l !== '0 || data_l !== 32'h04030201 || data_m !== 32'h01020304 ||
            act_status() !== exp_status()) begin
            n_fails++;
            $display("FAIL rx_hold act=%h/%h cnt=%0d exp=04030201/01020304 cnt=0",
                     data_l, data_m, count_l);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        idle_inputs();
        load = 1'b1; data = 32'h44332211; tick();
        load = 1'b0; shift_en = 1'b1; word = 8'hA0; tick();
        load = 1'b1; data = 32'hDDCCBBAA; tick();
        load = 1'b0; shift_en = 1'b0; out_load = 1'b1;
        #1;
        n_checks++;
        if (data_l !== 32'hDDCCBBAA || data_m !== 32'hDDCCBBAA || count_l !== CW'(N) ||
            done_l !== 1'b0 || act_status() !== exp_status()) begin
            n_fails++;
            $display("FAIL collision act=%h/%h status=%h exp=ddccbbaa status=%h",
                     data_l, data_m, act_status(), exp_status());
        end
        idle_inputs();
    endtask

    task automatic test_gaps();
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        idle_inputs();
        load = 1'b1; data = $urandom; tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift_en = pat[i];
            word = 8'($urandom_range(0, 255));
            tick();
            n_checks++;
            if (act_status() !== exp_status()) begin
                n_fails++;
                $display("FAIL gaps[%0d] act=%h exp=%h", i, act_status(), exp_status());
            end
        end
        n_checks++;
        if (count_l !== CW'(N - 2)) begin
            n_fails++;
            $display("FAIL gaps_count act=%0d exp=%0d", count_l, N - 2);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 15) == 0);
            start    = ($urandom_range(0, 15) == 0);
            shift_en = ($urandom_range(0, 3) != 0);
            out_load = $urandom_range(0, 1);
            word     = 8'($urandom_range(0, 255));
            data     = $urandom;
            tick();
            n_checks++;
            if (act_status() !== exp_status() ||
                data_l !== (out_load ? pack_l() : '0) ||
                data_m !== (out_load ? pack_m() : '0)) begin
                n_fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d] act=%h %h/%h exp=%h %h/%h", i, act_status(),
                             data_l, data_m, exp_status(), pack_l(), pack_m());
            end
        end
        idle_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_full_session();
        test_receive_only();
        test_collision();
        test_gaps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mod_shift_reg_words.md
# mod_shift_reg_words

Parametrised word-serial shift register: a wide parallel buffer of N words of W bits, loaded in one cycle, serialised one word per shift enable while new words enter from the opposite end. Successor to the fixed 2048x32 shift buffer in the crypto/bignum datapath. Adds:
- configurable width, depth and shift direction
- a word counter with busy/done status
- a receive-only start mode
- asynchronous active-low reset

Sits between the Avalon-side word FIFOs and the wide arithmetic cores.

## Interface
Parameters:
- W, 32, word width in bits (>=1)
- N, 64, number of words held (>=2); buffer width is W*N
- LSB_FIRST, 1, 1: word 0 (bits W-1:0) shifts out first and new words enter at word N-1; 0: word N-1 shifts out first and new words enter at word 0
- CW, derived $clog2(N+1), counter width; not to be overridden

Ports (one clock; reset is asynchronous and active-low):
- iClk  in  1  clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iLoad  in  1  parallel load of iData, starts a shift session
- iStart  in  1  start a receive-only session without loading
- iData  in  W*N  parallel load data
- iShiftEn  in  1  shift one word this cycle (honoured only in BUSY)
- iWord  in  W  word entering the buffer on a shift
- oWord  out  W  word at the output end of the buffer (registered contents, no extra delay)
- iOutputLoad  in  1  gate for oData
- oData  out  W*N  buffer contents when iOutputLoad=1, else all zeros (combinational gate)
- oCount  out  CW  words remaining in the session
- oBusy  out  1  high in BUSY
- oDone  out  1  one-cycle pulse on the cycle after the last shift

## Operation
States: IDLE, BUSY, DONE.
- Reset (async, any time including mid-session): buffer=0, oCount=0, state=IDLE, oBusy=0, oDone=0. oWord=0 follows from the buffer. oData=0 regardless of iOutputLoad.
- iLoad=1 (any state): buffer<=iData, oCount<=N, state<=BUSY.
- iStart=1 with iLoad=0 (any state): buffer unchanged, oCount<=N, state<=BUSY.
- iLoad and iStart together: the load takes priority.
- iLoad or iStart together with iShiftEn: the load/start wins and no shift happens.
- BUSY with iShiftEn=1:
  - LSB_FIRST=1: buffer<={iWord, buffer[W*N-1:W]}.
  - LSB_FIRST=0: buffer<={buffer[W*(N-1)-1:0], iWord}.
  - oCount<=oCount-1.
  - If oCount was 1: state<=DONE and oDone<=1 for the following cycle only.
- iShiftEn in IDLE or DONE: ignored. Buffer and counter are held; oCount never wraps below 0.
- DONE: the buffer holds the N words shifted in, in arrival order (the first received word sits at the output end). The buffer stays readable via oData. The state holds until the next iLoad or iStart.
- oBusy = (state==BUSY).
- A new iLoad in BUSY aborts the session silently; no oDone is produced.

## Timing
- All state is registered on the iClk rising edge. Reset is the only asynchronous input.
- Load to first output word: oWord is valid the cycle after iLoad.
- Each accepted shift updates oWord on the next edge. Throughput is one word per cycle; iShiftEn may be held high continuously.
- An N-word session with iShiftEn held high:
  - iLoad at cycle 0, shifts at cycles 1..N
  - oBusy high cycles 1..N
  - oDone high at cycle N+1; oBusy low from cycle N+1
- The oData gate is combinational from iOutputLoad: zero-latency, no register.

## Structure
- Shared package mod_shift_pkg:
  - state enum (IDLE, BUSY, DONE)
  - a function computing CW from N
- Single module. The datapath is one shift register plus a down-counter; no sub-module is warranted.
- Shift direction is selected by a generate on LSB_FIRST, not by runtime muxing.

## Test plan
Bench configuration W=8, N=4 unless stated.
- Reset mid-session: iLoad 0x44332211, one shift, assert iRst_n=0 asynchronously -> oWord=0, oCount=0, oBusy=0 immediately, without waiting for a clock edge; iShiftEn ignored after release.
- LSB_FIRST=1 full session: load 0x44332211, iWord 0xA0,0xA1,0xA2,0xA3 with iShiftEn held -> oWord sequence 0x11,0x22,0x33,0x44; oDone one cycle after the 4th shift; oData=0xA3A2A1A0 with iOutputLoad=1 and 0 with iOutputLoad=0.
- LSB_FIRST=0 full session: same stimulus -> oWord sequence 0x44,0x33,0x22,0x11; final buffer 0xA0A1A2A3.
- Receive-only: after reset iStart, shift 0x01..0x04 -> oCount 4,3,2,1,0; oDone pulses once; a 5th iShiftEn in DONE leaves oCount=0 and the buffer unchanged.
- Collision: iLoad and iShiftEn in the same cycle during BUSY -> buffer=new iData, oCount=4, no shift, no oDone.
- Gaps: iShiftEn toggling 1,0,0,1 -> oCount decrements only on high cycles; oWord stable during the gaps.
